// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
// Sel constants use big-endian lane order: bit 3 is byte offset 0 (data bits 31:24).
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] SEL_B0 = 4'b1000;
    localparam logic [3:0] SEL_B1 = 4'b0100;
    localparam logic [3:0] SEL_B2 = 4'b0010;
    localparam logic [3:0] SEL_B3 = 4'b0001;
    localparam logic [3:0] SEL_H0 = 4'b1100;
    localparam logic [3:0] SEL_H1 = 4'b0011;
    localparam logic [3:0] SEL_W  = 4'b1111;

    localparam int WAIT_CNT_W = 4;

    function automatic logic sel_legal(input logic [3:0] sel);
        sel_legal = (sel == SEL_B0) || (sel == SEL_B1) || (sel == SEL_B2) ||
                    (sel == SEL_B3) || (sel == SEL_H0) || (sel == SEL_H1) ||
                    (sel == SEL_W);
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port word RAM with per-lane write enables and a registered read port.
// Only the read register is reset; the array contents survive reset.
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [3:0]            i_we,
    input  logic [31:0]           i_wdata,
    input  logic                  i_re,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [0:(2**ADDR_WIDTH)-1];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        for (int li = 0; li < 4; li++) begin
            if (i_we[li]) begin
                r_mem[i_addr][li*8 +: 8] <= i_wdata[li*8 +: 8];
            end
        end
    end

    // Read register only updates on loads, so it holds across stores.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data port responder: latches a request, waits WAIT_CYCLES, then accesses dmem_bank.
// Define DMEM_ERR_CHECK_EN to flag illegal byte selects and block their writes.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        err_o
);

    localparam logic [WAIT_CNT_W-1:0] LP_WAIT = WAIT_CNT_W'(WAIT_CYCLES);
    localparam logic [WAIT_CNT_W-1:0] LP_ONE  = WAIT_CNT_W'(1);

    state_t                r_state;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic                  r_we;
    logic [3:0]            r_sel;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_data;

    logic                  w_accept;
    logic                  w_enter_done;
    logic                  w_cur_we;
    logic [3:0]            w_cur_sel;
    logic [ADDR_WIDTH-1:0] w_cur_addr;
    logic [31:0]           w_cur_data;
    logic                  w_wr_ok;
    logic [3:0]            w_lane_we;
    logic                  w_re;
    logic                  w_unused;

    assign w_accept     = (r_state == ST_IDLE) && ce_i;
    assign w_enter_done = (w_accept && (WAIT_CYCLES == 0)) ||
                          ((r_state == ST_WAIT) && (r_cnt == LP_ONE));

    // With zero wait states the access happens on the acceptance edge, before the latch is valid.
    assign w_cur_we   = (r_state == ST_IDLE) ? we_i                     : r_we;
    assign w_cur_sel  = (r_state == ST_IDLE) ? sel_i                    : r_sel;
    assign w_cur_addr = (r_state == ST_IDLE) ? addr_i[ADDR_WIDTH+1:2]   : r_addr;
    assign w_cur_data = (r_state == ST_IDLE) ? data_i                   : r_data;

`ifdef DMEM_ERR_CHECK_EN
    logic r_err;

    assign w_wr_ok = sel_legal(w_cur_sel);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_enter_done && !w_wr_ok;
        end
    end

    assign err_o = r_err;
`else
    assign w_wr_ok = 1'b1;
    assign err_o   = 1'b0;
`endif

    assign w_lane_we = {4{rst && w_enter_done && w_cur_we && w_wr_ok}} & w_cur_sel;
    assign w_re      = rst && w_enter_done && !w_cur_we;

    assign stall_o  = rst && (w_accept || (r_state == ST_WAIT));
    assign w_unused = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ce_i) begin
                        r_we    <= we_i;
                        r_sel   <= sel_i;
                        r_addr  <= addr_i[ADDR_WIDTH+1:2];
                        r_data  <= data_i;
                        r_cnt   <= LP_WAIT;
                        r_state <= (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - LP_ONE;
                    if (r_cnt == LP_ONE) begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    dmem_bank #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .i_addr (w_cur_addr),
        .i_we   (w_lane_we),
        .i_wdata(w_cur_data),
        .i_re   (w_re),
        .o_rdata(data_o)
    );

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the MEM-stage data port. It accepts the stage's chip-enable/write-enable/byte-select request, services it against an internal word-organised RAM after a configurable number of wait states, and holds the pipeline with a stall signal until the access completes. It sits between the MEM stage and the data address space and replaces the zero-latency data RAM model. Byte lanes are big-endian: `sel[3]` selects data bits 31:24, which is byte address offset 0.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: word-address bits. RAM depth is 2^ADDR_WIDTH words.
- `WAIT_CYCLES`, default 1: wait states inserted before completion. Legal range is 0..15.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `ce_i`  in  1  request valid (the MEM stage's chip enable).
- `we_i`  in  1  1 = store, 0 = load.
- `addr_i`  in  32  byte address. Bits [ADDR_WIDTH+1:2] index the RAM. Higher bits are ignored, so addresses alias.
- `sel_i`  in  4  byte-lane enables, big-endian lane order.
- `data_i`  in  32  store data, already replicated onto lanes by the requester.
- `data_o`  out  32  load data, full word, registered.
- `stall_o`  out  1  1 = the requester must hold its request stable.
- `err_o`  out  1  illegal-select flag. Present only with `DMEM_ERR_CHECK_EN`; tied to 0 otherwise.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If `ce_i`=1, latch `addr_i`, `sel_i`, `we_i` and `data_i`, and load the counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, otherwise go to DONE.
- WAIT: decrement the counter each cycle. When the counter reaches 1, go to DONE.
- Access on entry to DONE (the same edge as the DONE transition):
  - Store: each lane with sel=1 is written from the latched data. Lanes with sel=0 are unchanged. sel=0000 writes nothing.
  - Load: `data_o` is loaded with the full RAM word, regardless of sel. The requester extracts and extends the bytes it needs.
- DONE:
  - `stall_o`=0 and `data_o` is valid, for exactly one cycle.
  - The next state is always IDLE. DONE never accepts a new request.
- `stall_o` (combinational) = (state==IDLE && `ce_i`) || state==WAIT.
- On a store, `data_o` holds its previous value.
- The latched request is used for the access. Changes to the inputs after acceptance are ignored.

## Timing
- Reset (`rst`=0 at an edge):
  - state goes to IDLE, the counter to 0, `data_o` to 0 and `err_o` to 0.
  - `stall_o` is forced to 0 while `rst`=0.
  - RAM contents are not reset.
- Reset asserted in WAIT aborts the request; no write is performed.
- Latency from the IDLE acceptance cycle to the DONE cycle is WAIT_CYCLES+1.
  - Example: WAIT_CYCLES=0 gives a 1-cycle stall, with DONE on the next cycle.
- Back-to-back requests: at least one IDLE cycle lies between two DONE cycles. Throughput is one access per WAIT_CYCLES+2 cycles.
- A load following a store to the same word returns the new data, because the write is committed before the later acceptance.
- `ce_i`=0 in IDLE: no state change and `stall_o`=0.

## Configuration
- `DMEM_ERR_CHECK_EN` defined:
  - The latched sel is checked against the legal set 1000, 0100, 0010, 0001, 1100, 0011, 1111.
  - An illegal sel, including 0000, raises `err_o`=1 for the DONE cycle only and suppresses the store write.
  - Loads with an illegal sel still return the word.
- Not defined:
  - `err_o` is constant 0 and no check logic is built.
  - Any sel pattern is written as given.

## Structure
- Shared package `dmem_pkg`:
  - FSM state enum.
  - `SEL_B0..SEL_B3`, `SEL_H0`, `SEL_H1`, `SEL_W` constants.
  - `WAIT_CNT_W`=4.
- Sub-module `dmem_bank`:
  - single-port, 2^ADDR_WIDTH x 32 RAM with 4 lane write enables and a registered read port.
  - Instantiated once; the FSM drives its enables.

## Test plan
- Reset, then a store word: WAIT_CYCLES=1, addr=0x40, sel=1111, data=0xDEADBEEF.
  - `stall_o`=1 for 2 cycles, then DONE.
  - A subsequent load of 0x40 returns 0xDEADBEEF in its DONE cycle.
- Byte store over an existing word: word 0x40 holds 0xDEADBEEF; store addr=0x41, sel=0100, data=0x5A5A5A5A.
  - A load of 0x40 returns 0xDE5ABEEF.
- Halfword store over an existing word: word 0x40 holds 0xDE5ABEEF; store addr=0x42, sel=0011, data=0x12341234.
  - A load returns 0xDE5A1234.
- WAIT_CYCLES=0 with `ce_i` held across back-to-back loads to 0x0 and 0x4.
  - Stall pattern 1,0,1,0.
  - Each `data_o` matches its word.
- Reset during WAIT: WAIT_CYCLES=3, store to 0x80 of 0xFFFFFFFF; `rst`=0 in the 2nd WAIT cycle.
  - After reset, a load of 0x80 returns the old value.
  - `stall_o`=0 while `rst`=0.
- With `DMEM_ERR_CHECK_EN`, store sel=0110 to 0x10:
  - `err_o`=1 in DONE only.
  - Word 0x10 is unchanged.
- Without the macro, the same store writes lanes 2 and 1, and `err_o`=0.
